e203_exu_longp_rob: RTL and testbench

- Per-itag result buffer sitting between the long-pipe producers (LSU, NICE) and the long-pipe write-back arbiter.
- Producers may complete out of order. Each result is parked in the slot indexed by its itag.
- Results are released strictly in OITF retire order (oitf_ret_ptr), so the downstream write-back never stalls a producer waiting for its turn.

---
 rtl/e203_exu_longp_rob.sv | 173 +++++++++++++++++
 tb/tb_e203_exu_longp_rob.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_longp_rob.sv
// e203_exu_longp_rob: per-itag result buffer between the long-pipe
// producers (LSU, NICE) and the long-pipe write-back arbiter.
// Results land in the slot named by their itag in any order and leave in
// OITF retire order (oitf_ret_ptr).
// Optional feature macro: E203_LONGP_ROB_BYPASS_EN -- when defined, a result
// arriving for the empty head slot is forwarded to wbck_o in the same cycle.
module e203_exu_longp_rob #(
    parameter int ITAG_W = 2,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_i_valid,
    output logic              lsu_i_ready,
    input  logic [DW-1:0]     lsu_i_wdat,
    input  logic [ITAG_W-1:0] lsu_i_itag,
    input  logic              lsu_i_err,
    input  logic              nice_i_valid,
    output logic              nice_i_ready,
    input  logic [DW-1:0]     nice_i_wdat,
    input  logic [ITAG_W-1:0] nice_i_itag,
    input  logic              nice_i_err,
    input  logic              oitf_empty,
    input  logic [ITAG_W-1:0] oitf_ret_ptr,
    output logic              wbck_o_valid,
    input  logic              wbck_o_ready,
    output logic [DW-1:0]     wbck_o_wdat,
    output logic [ITAG_W-1:0] wbck_o_itag,
    output logic              wbck_o_err,
    output logic              wbck_o_src,
    output logic [ITAG_W:0]   rob_cnt,
    output logic              rob_collide
);
    localparam int DEPTH = 1 << ITAG_W;

    logic          slot_vld_reg [DEPTH];
    logic          slot_src_reg [DEPTH];
    logic          slot_err_reg [DEPTH];
    logic [DW-1:0] slot_dat_reg [DEPTH];

    logic [ITAG_W:0]   rob_cnt_reg;
    logic [ITAG_W:0]   rob_cnt_next;
    logic [ITAG_W+1:0] cnt_sum;
    logic              rob_collide_reg;

    logic same_itag;
    logic lsu_hs;
    logic nice_hs;
    logic lsu_wr;
    logic nice_wr;
    logic head_vld;
    logic slot_rel;

    // LSU owns any itag both sources present in the same cycle
    assign same_itag    = (lsu_i_itag == nice_i_itag);
    assign lsu_i_ready  = ~slot_vld_reg[lsu_i_itag];
    assign nice_i_ready = ~slot_vld_reg[nice_i_itag] & ~(lsu_i_valid & same_itag);
    assign lsu_hs       = lsu_i_valid & lsu_i_ready;
    assign nice_hs      = nice_i_valid & nice_i_ready;

    // Head slot release: only a parked result ever frees a slot
    assign head_vld    = ~oitf_empty & slot_vld_reg[oitf_ret_ptr];
    assign slot_rel    = head_vld & wbck_o_ready;
    assign wbck_o_itag = oitf_ret_ptr;

`ifdef E203_LONGP_ROB_BYPASS_EN
    logic head_free;
    logic lsu_byp;
    logic nice_byp;

    assign head_free = ~oitf_empty & ~slot_vld_reg[oitf_ret_ptr];
    assign lsu_byp   = lsu_hs & head_free & (lsu_i_itag == oitf_ret_ptr);
    assign nice_byp  = nice_hs & head_free & (nice_i_itag == oitf_ret_ptr) & ~lsu_byp;

    // A forwarded result taken downstream this cycle never occupies a slot
    assign lsu_wr  = lsu_hs & ~(lsu_byp & wbck_o_ready);
    assign nice_wr = nice_hs & ~(nice_byp & wbck_o_ready);

    // Head payload: parked slot, else a forwarded incoming result
    always_comb begin
        wbck_o_valid = head_vld;
        wbck_o_wdat  = slot_dat_reg[oitf_ret_ptr];
        wbck_o_err   = slot_err_reg[oitf_ret_ptr];
        wbck_o_src   = slot_src_reg[oitf_ret_ptr];
        if (lsu_byp) begin
            wbck_o_valid = 1'b1;
            wbck_o_wdat  = lsu_i_wdat;
            wbck_o_err   = lsu_i_err;
            wbck_o_src   = 1'b0;
        end else if (nice_byp) begin
            wbck_o_valid = 1'b1;
            wbck_o_wdat  = nice_i_wdat;
            wbck_o_err   = nice_i_err;
            wbck_o_src   = 1'b1;
        end
    end
`else
    assign lsu_wr       = lsu_hs;
    assign nice_wr      = nice_hs;
    assign wbck_o_valid = head_vld;
    assign wbck_o_wdat  = slot_dat_reg[oitf_ret_ptr];
    assign wbck_o_err   = slot_err_reg[oitf_ret_ptr];
    assign wbck_o_src   = slot_src_reg[oitf_ret_ptr];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic lsu_hit;
            logic nice_hit;
            logic rel_hit;

            assign lsu_hit  = lsu_wr  & (lsu_i_itag   == ITAG_W'(gi));
            assign nice_hit = nice_wr & (nice_i_itag  == ITAG_W'(gi));
            assign rel_hit  = slot_rel & (oitf_ret_ptr == ITAG_W'(gi));

            // Slot control: fill on accept, empty on release (never both at once)
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_vld_reg[gi] <= 1'b0;
                    slot_src_reg[gi] <= 1'b0;
                    slot_err_reg[gi] <= 1'b0;
                end else if (lsu_hit) begin
                    slot_vld_reg[gi] <= 1'b1;
                    slot_src_reg[gi] <= 1'b0;
                    slot_err_reg[gi] <= lsu_i_err;
                end else if (nice_hit) begin
                    slot_vld_reg[gi] <= 1'b1;
                    slot_src_reg[gi] <= 1'b1;
                    slot_err_reg[gi] <= nice_i_err;
                end else if (rel_hit) begin
                    slot_vld_reg[gi] <= 1'b0;
                end
            end

            // Slot data: unreset storage, qualified by slot_vld_reg
            always_ff @(posedge clk) begin
                if (lsu_hit) begin
                    slot_dat_reg[gi] <= lsu_i_wdat;
                end else if (nice_hit) begin
                    slot_dat_reg[gi] <= nice_i_wdat;
                end
            end
        end
    endgenerate

    // Occupancy: net -1..+2 per cycle, clamped at DEPTH
    always_comb begin
        cnt_sum = {1'b0, rob_cnt_reg} + (ITAG_W+2)'(lsu_wr) + (ITAG_W+2)'(nice_wr)
                  - (ITAG_W+2)'(slot_rel);
        if (cnt_sum > (ITAG_W+2)'(DEPTH)) begin
            rob_cnt_next = (ITAG_W+1)'(DEPTH);
        end else begin
            rob_cnt_next = cnt_sum[ITAG_W:0];
        end
    end

    // Occupancy counter and sticky same-itag collision flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rob_cnt_reg     <= '0;
            rob_collide_reg <= 1'b0;
        end else begin
            rob_cnt_reg <= rob_cnt_next;
            if (lsu_i_valid & nice_i_valid & same_itag) begin
                rob_collide_reg <= 1'b1;
            end
        end
    end

    assign rob_cnt     = rob_cnt_reg;
    assign rob_collide = rob_collide_reg;
endmodule

// File: tb/tb_e203_exu_longp_rob.sv
// Testbench for e203_exu_longp_rob: directed scenarios plus a randomized run,
// all checked against a slot-array reference model of the result buffer.
module tb_e203_exu_longp_rob;
    localparam int ITAG_W = 2;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              lsu_i_valid;
    logic              lsu_i_ready;
    logic [DW-1:0]     lsu_i_wdat;
    logic [ITAG_W-1:0] lsu_i_itag;
    logic              lsu_i_err;
    logic              nice_i_valid;
    logic              nice_i_ready;
    logic [DW-1:0]     nice_i_wdat;
    logic [ITAG_W-1:0] nice_i_itag;
    logic              nice_i_err;
    logic              oitf_empty;
    logic [ITAG_W-1:0] oitf_ret_ptr;
    logic              wbck_o_valid;
    logic              wbck_o_ready;
    logic [DW-1:0]     wbck_o_wdat;
    logic [ITAG_W-1:0] wbck_o_itag;
    logic              wbck_o_err;
    logic              wbck_o_src;
    logic [ITAG_W:0]   rob_cnt;
    logic              rob_collide;

    e203_exu_longp_rob #(.ITAG_W(ITAG_W), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_i_valid(lsu_i_valid), .lsu_i_ready(lsu_i_ready), .lsu_i_wdat(lsu_i_wdat),
        .lsu_i_itag(lsu_i_itag), .lsu_i_err(lsu_i_err),
        .nice_i_valid(nice_i_valid), .nice_i_ready(nice_i_ready), .nice_i_wdat(nice_i_wdat),
        .nice_i_itag(nice_i_itag), .nice_i_err(nice_i_err),
        .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr),
        .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready), .wbck_o_wdat(wbck_o_wdat),
        .wbck_o_itag(wbck_o_itag), .wbck_o_err(wbck_o_err), .wbck_o_src(wbck_o_src),
        .rob_cnt(rob_cnt), .rob_collide(rob_collide)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: which itags hold a parked result, and what it is
    bit        m_vld [DEPTH];
    bit [31:0] m_dat [DEPTH];
    bit        m_src [DEPTH];
    bit        m_err [DEPTH];
    bit        m_col;

    // Expected outputs for the current cycle
    bit        e_lr, e_nr, e_v, e_src, e_err, e_col, byp_l, byp_n;
    bit [31:0] e_dat;
    int        e_cnt;

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_vld[k] = 0; m_src[k] = 0; m_err[k] = 0;
        end
        m_col = 0;
    endtask

    // Expected outputs from model contents and current inputs
    task automatic model_eval();
        e_lr  = !m_vld[lsu_i_itag];
        e_nr  = !m_vld[nice_i_itag] && !(lsu_i_valid && lsu_i_itag == nice_i_itag);
        e_v   = !oitf_empty && m_vld[oitf_ret_ptr];
        e_dat = m_dat[oitf_ret_ptr];
        e_src = m_src[oitf_ret_ptr];
        e_err = m_err[oitf_ret_ptr];
        byp_l = 0;
        byp_n = 0;
`ifdef E203_LONGP_ROB_BYPASS_EN
        if (!oitf_empty && !m_vld[oitf_ret_ptr]) begin
            if (lsu_i_valid && e_lr && lsu_i_itag == oitf_ret_ptr) begin
                byp_l = 1; e_v = 1; e_dat = lsu_i_wdat; e_src = 0; e_err = lsu_i_err;
            end else if (nice_i_valid && e_nr && nice_i_itag == oitf_ret_ptr) begin
                byp_n = 1; e_v = 1; e_dat = nice_i_wdat; e_src = 1; e_err = nice_i_err;
            end
        end
`endif
        e_cnt = 0;
        for (int k = 0; k < DEPTH; k++) e_cnt += int'(m_vld[k]);
        e_col = m_col;
    endtask

    // Apply this cycle's transactions to the model
    task automatic model_commit();
        if (e_v && wbck_o_ready) begin
            $display("[%0t] release itag=%0d dat=%h src=%0d err=%0d", $time, oitf_ret_ptr, e_dat, e_src, e_err);
            if (!byp_l && !byp_n) m_vld[oitf_ret_ptr] = 0;
        end
        if (lsu_i_valid && e_lr) begin
            $display("[%0t] lsu accept itag=%0d dat=%h", $time, lsu_i_itag, lsu_i_wdat);
            if (!(byp_l && wbck_o_ready)) begin
                m_vld[lsu_i_itag] = 1; m_dat[lsu_i_itag] = lsu_i_wdat;
                m_src[lsu_i_itag] = 0; m_err[lsu_i_itag] = lsu_i_err;
            end
        end
        if (nice_i_valid && e_nr) begin
            $display("[%0t] nice accept itag=%0d dat=%h", $time, nice_i_itag, nice_i_wdat);
            if (!(byp_n && wbck_o_ready)) begin
                m_vld[nice_i_itag] = 1; m_dat[nice_i_itag] = nice_i_wdat;
                m_src[nice_i_itag] = 1; m_err[nice_i_itag] = nice_i_err;
            end
        end
        if (lsu_i_valid && nice_i_valid && lsu_i_itag == nice_i_itag) m_col = 1;
    endtask

    task automatic to_sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic to_next();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input bit lv, input bit [1:0] li, input bit [31:0] ld,
                         input bit nv, input bit [1:0] ni, input bit [31:0] nd,
                         input bit oe, input bit [1:0] p, input bit rdy);
        lsu_i_valid = lv; lsu_i_itag = li; lsu_i_wdat = ld; lsu_i_err = 0;
        nice_i_valid = nv; nice_i_itag = ni; nice_i_wdat = nd; nice_i_err = 0;
        oitf_empty = oe; oitf_ret_ptr = p; wbck_o_ready = rdy;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        to_sample();
        checks++; if (rob_cnt !== 3'd0) $display("FAIL reset_cnt got=%0d want=0", rob_cnt); else passes++;
        checks++; if (wbck_o_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", wbck_o_valid); else passes++;
        checks++; if (rob_collide !== 1'b0) $display("FAIL reset_collide got=%0b want=0", rob_collide); else passes++;
        checks++; if (lsu_i_ready !== 1'b1) $display("FAIL reset_lsu_ready got=%0b want=1", lsu_i_ready); else passes++;
        to_next();
    endtask

    // LSU itag1 and NICE itag0 together, drained in ptr order 0 then 1
    task automatic test_two_sources();
        drive(1, 1, 32'h1111, 1, 0, 32'h2222, 0, 0, 1);
        to_sample();
        checks++; if (lsu_i_ready !== e_lr || nice_i_ready !== e_nr) $display("FAIL two_ready got=%0b%0b want=%0b%0b", lsu_i_ready, nice_i_ready, e_lr, e_nr); else passes++;
        checks++; if (wbck_o_valid !== e_v) $display("FAIL two_valid0 got=%0b want=%0b", wbck_o_valid, e_v); else passes++;
        to_next();
        for (int p = 0; p < 3; p++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 2'(p), 1);
            to_sample();
            checks++; if (rob_cnt !== 3'(e_cnt)) $display("FAIL two_cnt step=%0d got=%0d want=%0d", p, rob_cnt, e_cnt); else passes++;
            checks++; if (wbck_o_valid !== e_v) $display("FAIL two_valid step=%0d got=%0b want=%0b", p, wbck_o_valid, e_v); else passes++;
            if (e_v) begin
                checks++; if (wbck_o_wdat !== e_dat || wbck_o_src !== e_src) $display("FAIL two_payload step=%0d got=%h/%0b want=%h/%0b", p, wbck_o_wdat, wbck_o_src, e_dat, e_src); else passes++;
            end
            to_next();
        end
    endtask

    // Both sources on itag 2: LSU wins, collide sticks, NICE waits for release
    task automatic test_collide();
        drive(1, 2, 32'h0000_00A2, 1, 2, 32'h0000_00B2, 1, 2, 1);
        to_sample();
        checks++; if (lsu_i_ready !== 1'b1) $display("FAIL col_lsu_ready got=%0b want=1", lsu_i_ready); else passes++;
        checks++; if (nice_i_ready !== 1'b0) $display("FAIL col_nice_ready got=%0b want=0", nice_i_ready); else passes++;
        to_next();
        for (int s = 0; s < 4; s++) begin
            drive(0, 0, 0, 1, 2, 32'h0000_00B2, 0, 2, 1);
            if (s == 3) nice_i_valid = 0;
            to_sample();
            checks++; if (rob_collide !== 1'b1) $display("FAIL col_sticky step=%0d got=%0b want=1", s, rob_collide); else passes++;
            checks++; if (nice_i_ready !== e_nr) $display("FAIL col_nice_wait step=%0d got=%0b want=%0b", s, nice_i_ready, e_nr); else passes++;
            checks++; if (wbck_o_valid !== e_v) $display("FAIL col_valid step=%0d got=%0b want=%0b", s, wbck_o_valid, e_v); else passes++;
            if (e_v) begin
                checks++; if (wbck_o_wdat !== e_dat || wbck_o_src !== e_src) $display("FAIL col_payload step=%0d got=%h/%0b want=%h/%0b", s, wbck_o_wdat, wbck_o_src, e_dat, e_src); else passes++;
            end
            to_next();
        end
    endtask

    // Fill all slots with ptr=3 and ready low: full, stalled, head stable
    task automatic test_full_hold();
        bit [31:0] d3 = 32'hD3D3_0003;
        drive(1, 0, 32'hD0, 1, 1, 32'hD1, 0, 3, 0);
        to_sample(); to_next();
        drive(1, 2, 32'hD2, 1, 3, d3, 0, 3, 0);
        to_sample(); to_next();
        for (int s = 0; s < 5; s++) begin
            drive(1, 2'($urandom_range(0, 3)), 32'hEE, 1, 2'($urandom_range(0, 3)), 32'hFF, 0, 3, 0);
            to_sample();
            checks++; if (rob_cnt !== 3'd4 || e_cnt != 4) $display("FAIL full_cnt got=%0d want=4", rob_cnt); else passes++;
            checks++; if (lsu_i_ready !== 1'b0 || nice_i_ready !== 1'b0) $display("FAIL full_ready got=%0b%0b want=00", lsu_i_ready, nice_i_ready); else passes++;
            checks++; if (wbck_o_valid !== 1'b1 || wbck_o_wdat !== d3 || wbck_o_src !== 1'b1) $display("FAIL full_hold step=%0d got=%0b/%h want=1/%h", s, wbck_o_valid, wbck_o_wdat, d3); else passes++;
            to_next();
        end
        for (int s = 0; s < 4; s++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 2'(s + 3), 1);
            to_sample();
            checks++; if (wbck_o_valid !== e_v || (e_v && wbck_o_wdat !== e_dat)) $display("FAIL drain step=%0d got=%0b/%h want=%0b/%h", s, wbck_o_valid, wbck_o_wdat, e_v, e_dat); else passes++;
            to_next();
        end
    endtask

    // oitf_empty masks a valid head slot without dropping it
    task automatic test_oitf_empty();
        drive(1, 0, 32'h0E0E, 0, 0, 0, 1, 0, 1);
        to_sample(); to_next();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int s = 0; s < 2; s++) begin
            to_sample();
            checks++; if (wbck_o_valid !== 1'b0) $display("FAIL empty_mask got=%0b want=0", wbck_o_valid); else passes++;
            checks++; if (rob_cnt !== 3'(e_cnt)) $display("FAIL empty_cnt got=%0d want=%0d", rob_cnt, e_cnt); else passes++;
            to_next();
        end
        oitf_empty = 0;
        #1;
        checks++; if (wbck_o_valid !== 1'b1 || wbck_o_wdat !== 32'h0E0E) $display("FAIL empty_unmask got=%0b/%h want=1/0000e0e", wbck_o_valid, wbck_o_wdat); else passes++;
        to_sample(); to_next();
    endtask

    // Asynchronous reset with three slots held
    task automatic test_async_reset();
        drive(1, 0, 32'hA0, 1, 1, 32'hA1, 1, 0, 0);
        to_sample(); to_next();
        drive(1, 2, 32'hA2, 1, 2, 32'hB2, 0, 0, 0);
        to_sample(); to_next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_sample();
        checks++; if (rob_cnt !== 3'd3 || wbck_o_valid !== 1'b1) $display("FAIL prereset got=%0d/%0b want=3/1", rob_cnt, wbck_o_valid); else passes++;
        #2 rst_n = 0;
        #1;
        checks++; if (wbck_o_valid !== 1'b0) $display("FAIL arst_valid got=%0b want=0", wbck_o_valid); else passes++;
        checks++; if (rob_cnt !== 3'd0) $display("FAIL arst_cnt got=%0d want=0", rob_cnt); else passes++;
        checks++; if (rob_collide !== 1'b0) $display("FAIL arst_collide got=%0b want=0", rob_collide); else passes++;
        checks++; if (wbck_o_err !== 1'b0 || wbck_o_src !== 1'b0) $display("FAIL arst_flags got=%0b%0b want=00", wbck_o_err, wbck_o_src); else passes++;
        model_clear();
        @(posedge clk); #2 rst_n = 1;
        @(posedge clk); #1;
        drive(1, 1, 32'h5151, 0, 0, 0, 1, 0, 1);
        to_sample(); to_next();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        to_sample();
        checks++; if (rob_cnt !== 3'd1) $display("FAIL arst_first_cnt got=%0d want=1", rob_cnt); else passes++;
        to_next();
        oitf_ret_ptr = 1; oitf_empty = 0;
        to_sample(); to_next();
    endtask

    // Head latency for a result into an empty head slot
    task automatic test_latency();
        drive(1, 0, 32'hABCD, 0, 0, 0, 0, 0, 1);
        to_sample();
`ifdef E203_LONGP_ROB_BYPASS_EN
        checks++; if (wbck_o_valid !== 1'b1 || wbck_o_wdat !== 32'hABCD) $display("FAIL byp_same got=%0b/%h want=1/0000abcd", wbck_o_valid, wbck_o_wdat); else passes++;
`else
        checks++; if (wbck_o_valid !== 1'b0) $display("FAIL lat_same got=%0b want=0", wbck_o_valid); else passes++;
`endif
        to_next();
        lsu_i_valid = 0;
        to_sample();
        checks++; if (wbck_o_valid !== e_v || (e_v && wbck_o_wdat !== e_dat)) $display("FAIL lat_next got=%0b/%h want=%0b/%h", wbck_o_valid, wbck_o_wdat, e_v, e_dat); else passes++;
        checks++; if (rob_cnt !== 3'(e_cnt)) $display("FAIL lat_cnt got=%0d want=%0d", rob_cnt, e_cnt); else passes++;
        to_next();
        to_sample(); to_next();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            lsu_i_valid  = $urandom_range(0, 1) == 1;
            lsu_i_itag   = 2'($urandom_range(0, 3));
            lsu_i_wdat   = $urandom;
            lsu_i_err    = $urandom_range(0, 3) == 0;
            nice_i_valid = $urandom_range(0, 1) == 1;
            nice_i_itag  = 2'($urandom_range(0, 3));
            nice_i_wdat  = $urandom;
            nice_i_err   = $urandom_range(0, 3) == 0;
            oitf_empty   = $urandom_range(0, 7) == 0;
            oitf_ret_ptr = 2'($urandom_range(0, 3));
            wbck_o_ready = $urandom_range(0, 9) < 7;
            to_sample();
            checks++; if (lsu_i_ready !== e_lr || nice_i_ready !== e_nr) $display("FAIL rnd_ready i=%0d got=%0b%0b want=%0b%0b", i, lsu_i_ready, nice_i_ready, e_lr, e_nr); else passes++;
            checks++; if (wbck_o_valid !== e_v) $display("FAIL rnd_valid i=%0d got=%0b want=%0b", i, wbck_o_valid, e_v); else passes++;
            checks++; if (rob_cnt !== 3'(e_cnt) || rob_collide !== e_col) $display("FAIL rnd_state i=%0d got=%0d/%0b want=%0d/%0b", i, rob_cnt, rob_collide, e_cnt, e_col); else passes++;
            if (e_v) begin
                checks++;
                if (wbck_o_wdat !== e_dat || wbck_o_src !== e_src || wbck_o_err !== e_err || wbck_o_itag !== oitf_ret_ptr)
                    $display("FAIL rnd_payload i=%0d got=%h/%0b/%0b/%0d want=%h/%0b/%0b/%0d", i, wbck_o_wdat, wbck_o_src, wbck_o_err, wbck_o_itag, e_dat, e_src, e_err, oitf_ret_ptr);
                else passes++;
            end
            to_next();
        end
    endtask

    initial begin
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        test_reset();
        test_two_sources();
        test_latency();
        test_collide();
        test_full_hold();
        test_oitf_empty();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
